// File: rtl/demux_1to8_32bit_if.sv
// rtl/demux_1to8_32bit_if.sv - producer/consumer bus for the 1-to-8 32-bit distributor
// master = producer + consumers side, slave = the distributor itself.
interface demux_1to8_32bit_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     In;
  logic                 InValid;
  logic [2:0]           Select;
  logic                 InReady;
  logic [WIDTH-1:0]     Out0;
  logic [WIDTH-1:0]     Out1;
  logic [WIDTH-1:0]     Out2;
  logic [WIDTH-1:0]     Out3;
  logic [WIDTH-1:0]     Out4;
  logic [WIDTH-1:0]     Out5;
  logic [WIDTH-1:0]     Out6;
  logic [WIDTH-1:0]     Out7;
  logic [7:0]           OutValid;
  logic [7:0]           OutReady;
  logic [CNT_WIDTH-1:0] Count;

  modport master (
    output In, InValid, Select, OutReady,
    input  InReady, Out0, Out1, Out2, Out3, Out4, Out5, Out6, Out7, OutValid, Count
  );

  modport slave (
    input  In, InValid, Select, OutReady,
    output InReady, Out0, Out1, Out2, Out3, Out4, Out5, Out6, Out7, OutValid, Count
  );
endinterface

// File: rtl/demux_1to8_32bit.sv
// rtl/demux_1to8_32bit.sv - registered 1-to-8 word distributor with per-channel handshake
// One single-entry register per channel plus a wrapping accepted-word counter.
module demux_1to8_32bit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  demux_1to8_32bit_if.slave   bus
);

  logic [WIDTH-1:0]     data_q [8];
  logic [WIDTH-1:0]     data_d [8];
  logic [7:0]           valid_q;
  logic [7:0]           valid_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  logic [7:0] sel_onehot;
  logic [7:0] load;
  logic       sel_ready;
  logic       in_ready;
  logic       accept;

  // An X/Z select matches no case item, so it decodes to no channel and InReady stays low.
  always_comb begin
    sel_onehot = 8'h00;
    case (bus.Select)
      3'd0:    sel_onehot = 8'h01;
      3'd1:    sel_onehot = 8'h02;
      3'd2:    sel_onehot = 8'h04;
      3'd3:    sel_onehot = 8'h08;
      3'd4:    sel_onehot = 8'h10;
      3'd5:    sel_onehot = 8'h20;
      3'd6:    sel_onehot = 8'h40;
      3'd7:    sel_onehot = 8'h80;
      default: sel_onehot = 8'h00;
    endcase
  end

  assign sel_ready = |(sel_onehot & (~valid_q | bus.OutReady));
  assign in_ready  = sel_ready & ~Reset;
  assign accept    = bus.InValid & in_ready;
  assign load      = sel_onehot & {8{accept}};

  // A load wins over a same-cycle delivery, so the channel stays valid with no bubble.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      data_d[k] = load[k] ? bus.In : data_q[k];
    end
    valid_d = (valid_q & ~bus.OutReady) | load;
    count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, accept};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= 8'h00;
      count_q <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= data_d[k];
      end
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.Out0     = data_q[0];
  assign bus.Out1     = data_q[1];
  assign bus.Out2     = data_q[2];
  assign bus.Out3     = data_q[3];
  assign bus.Out4     = data_q[4];
  assign bus.Out5     = data_q[5];
  assign bus.Out6     = data_q[6];
  assign bus.Out7     = data_q[7];
  assign bus.OutValid = valid_q;
  assign bus.Count    = count_q;

endmodule
